branch_resolve_unit: RTL

//  Back end of the 2-bit saturating branch predictor.

---
 rtl/branch_resolve_unit_if.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// Module   : branch_resolve_unit_if
// Brief    : Prediction, resolution and counter write-back bundle of the
//            branch resolve unit.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface branch_resolve_unit_if #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int MISS_W = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              pred_valid;
  logic              pred_ready;
  logic [IDX_W-1:0]  pred_idx;
  logic              pred_taken;
  logic [CNT_W-1:0]  pred_counter;
  logic              res_valid;
  logic              res_taken;
  logic              res_err;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [CNT_W-1:0]  upd_counter;
  logic              mispredict;
  logic [MISS_W-1:0] miss_count;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  pred_valid, pred_idx, pred_taken, pred_counter, res_valid, res_taken,
    output pred_ready, res_err, upd_valid, upd_idx, upd_counter, mispredict,
           miss_count, occupancy
  );

  modport master (
    output pred_valid, pred_idx, pred_taken, pred_counter, res_valid, res_taken,
    input  pred_ready, res_err, upd_valid, upd_idx, upd_counter, mispredict,
           miss_count, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// Module   : branch_resolve_unit
// Brief    : In-order retire queue for a 2-bit saturating branch predictor;
//            resolves branches, writes back counters, flushes on mispredict.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 2,
  parameter int MISS_W = 16
) (
  input  wire                   clock,
  input  wire                   reset_n,
  branch_resolve_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
  localparam logic [MISS_W-1:0] c_miss_max = '1;
  localparam logic [OCC_W-1:0]  c_depth    = OCC_W'(DEPTH);

  logic [IDX_W-1:0]  r_mem_idx   [DEPTH];
  logic              r_mem_taken [DEPTH];
  logic [CNT_W-1:0]  r_mem_cnt   [DEPTH];

  logic [0:0]        r_state;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;

  logic              r_res_err;
  logic              r_upd_valid;
  logic [IDX_W-1:0]  r_upd_idx;
  logic [CNT_W-1:0]  r_upd_counter;
  logic              r_mispredict;
  logic [MISS_W-1:0] r_miss_count;
  logic [OCC_W-1:0]  r_occupancy;

  logic              w_ready;
  logic              w_push;
  logic              w_retire;
  logic              w_ignored;
  logic              w_miss;
  logic [IDX_W-1:0]  w_head_idx;
  logic              w_head_taken;
  logic [CNT_W-1:0]  w_head_cnt;
  logic [CNT_W-1:0]  w_new_cnt;
  logic [OCC_W-1:0]  w_count_next;

  always_comb begin
    w_ready      = (r_state == ST_RUN) && (r_count < c_depth);
    w_push       = bus.pred_valid && w_ready;
    w_retire     = bus.res_valid && (r_count != '0) && (r_state == ST_RUN);
    w_ignored    = bus.res_valid && !w_retire;
    w_head_idx   = r_mem_idx[r_rd_ptr];
    w_head_taken = r_mem_taken[r_rd_ptr];
    w_head_cnt   = r_mem_cnt[r_rd_ptr];
    w_miss       = w_retire && (bus.res_taken != w_head_taken);

    w_new_cnt = w_head_cnt;
    if (bus.res_taken) begin
      if (w_head_cnt != c_cnt_max) w_new_cnt = w_head_cnt + CNT_W'(1);
    end else begin
      if (w_head_cnt != '0) w_new_cnt = w_head_cnt - CNT_W'(1);
    end

    // A mispredict empties the queue and swallows any same-cycle (wrong-path) push
    w_count_next = r_count;
    if (w_miss)
      w_count_next = '0;
    else if (w_push && !w_retire)
      w_count_next = r_count + OCC_W'(1);
    else if (!w_push && w_retire)
      w_count_next = r_count - OCC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_idx[r_wr_ptr]   <= bus.pred_idx;
      r_mem_taken[r_wr_ptr] <= bus.pred_taken;
      r_mem_cnt[r_wr_ptr]   <= bus.pred_counter;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_res_err     <= 1'b0;
      r_upd_valid   <= 1'b0;
      r_upd_idx     <= '0;
      r_upd_counter <= '0;
      r_mispredict  <= 1'b0;
      r_miss_count  <= '0;
      r_occupancy   <= '0;
    end else begin
      r_count     <= w_count_next;
      r_occupancy <= w_count_next;
      r_res_err   <= w_ignored;
      r_upd_valid <= w_retire;
      r_mispredict <= w_miss;
      if (w_retire) begin
        r_upd_idx     <= w_head_idx;
        r_upd_counter <= w_new_cnt;
      end

      if (w_miss) begin
        r_rd_ptr <= r_wr_ptr;
        if (r_miss_count != c_miss_max) r_miss_count <= r_miss_count + MISS_W'(1);
      end else begin
        if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_retire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case (r_state)
        ST_RUN:   r_state <= w_miss ? ST_FLUSH : ST_RUN;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pred_ready  = w_ready;
  assign bus.res_err     = r_res_err;
  assign bus.upd_valid   = r_upd_valid;
  assign bus.upd_idx     = r_upd_idx;
  assign bus.upd_counter = r_upd_counter;
  assign bus.mispredict  = r_mispredict;
  assign bus.miss_count  = r_miss_count;
  assign bus.occupancy   = r_occupancy;

endmodule

`default_nettype wire
